// File: rtl/dice_face_rx.sv
// Receive side of the die counter: classifies face steps, drives pips, and hands out settled faces.
// Define DICE_FACE_RX_SUM_EN to add the roll_sum/roll_cnt accumulators.
module dice_face_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int RUN_W         = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       face,
  input  logic             ack,
  output logic [6:0]       pips,
  output logic [1:0]       dir,
  output logic [RUN_W-1:0] run_len,
  output logic [2:0]       result,
  output logic             result_valid,
`ifdef DICE_FACE_RX_SUM_EN
  output logic [7:0]       roll_sum,
  output logic [7:0]       roll_cnt,
`endif
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_TRACK, S_HOLD, S_REARM, S_FAULT} state_t;
  typedef enum logic [2:0] {C_HOLD, C_UP, C_DOWN, C_JUMP, C_ILL} cls_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  state_t           state_q, state_d;
  cls_t             last_cls_q, cls;
  logic [2:0]       prev_face_q, result_q, result_d;
  logic [6:0]       pips_q, pips_d;
  logic [1:0]       dir_q, dir_d;
  logic [RUN_W-1:0] run_len_q, run_len_d, run_inc;
  logic [3:0]       stable_cnt_q, stable_cnt_d;
  logic             result_valid_q, result_valid_d, err_q, err_d;
  logic             face_legal, prev_legal, fault_ev, step_ev, settled, accept;
  logic [2:0]       next_up, next_dn;

  always_comb begin
    face_legal = (face != 3'd0) && (face != 3'd7);
    prev_legal = (prev_face_q != 3'd0) && (prev_face_q != 3'd7);
    next_up    = (prev_face_q == 3'd6) ? 3'd1 : prev_face_q + 3'd1;
    next_dn    = (prev_face_q == 3'd1) ? 3'd6 : prev_face_q - 3'd1;
    // Up/down only make sense from a legal previous face; anything else is a jump.
    if (!face_legal)                          cls = C_ILL;
    else if (face == prev_face_q)             cls = C_HOLD;
    else if (prev_legal && face == next_up)   cls = C_UP;
    else if (prev_legal && face == next_dn)   cls = C_DOWN;
    else                                      cls = C_JUMP;
  end

  always_comb begin
    case (face)
      3'd1:    pips_d = 7'b0001000;
      3'd2:    pips_d = 7'b1000001;
      3'd3:    pips_d = 7'b1001001;
      3'd4:    pips_d = 7'b1100011;
      3'd5:    pips_d = 7'b1101011;
      3'd6:    pips_d = 7'b1110111;
      default: pips_d = 7'b0000000;
    endcase
  end

  always_comb begin
    run_inc = (run_len_q == {RUN_W{1'b1}}) ? run_len_q : run_len_q + RUN_W'(1);
    case (cls)
      C_UP:    run_len_d = (last_cls_q == C_UP)   ? run_inc : RUN_W'(1);
      C_DOWN:  run_len_d = (last_cls_q == C_DOWN) ? run_inc : RUN_W'(1);
      default: run_len_d = '0;
    endcase
    if (cls == C_HOLD)
      stable_cnt_d = (stable_cnt_q >= STABLE_MAX) ? STABLE_MAX : stable_cnt_q + 4'd1;
    else
      stable_cnt_d = 4'd0;
    fault_ev = (cls == C_JUMP) || (cls == C_ILL);
    step_ev  = (cls == C_UP) || (cls == C_DOWN);
    settled  = (stable_cnt_d == STABLE_MAX);
  end

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    accept         = 1'b0;
    case (cls)
      C_HOLD:  dir_d = 2'b00;
      C_UP:    dir_d = 2'b01;
      C_DOWN:  dir_d = 2'b10;
      default: dir_d = 2'b11;
    endcase
    case (state_q)
      S_IDLE: begin
        dir_d = 2'b00;
        if (face_legal) state_d = S_TRACK;
      end
      S_TRACK: begin
        if (fault_ev) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end else if (settled) begin
          state_d        = S_HOLD;
          result_d       = face;
          result_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A fault in the same cycle as ack wins; the result is not consumed.
        if (fault_ev) begin
          state_d        = S_FAULT;
          err_d          = 1'b1;
          result_valid_d = 1'b0;
        end else if (ack) begin
          state_d        = S_REARM;
          result_valid_d = 1'b0;
          accept         = 1'b1;
        end
      end
      S_REARM: begin
        if (fault_ev) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end else if (step_ev) begin
          state_d = S_TRACK;
        end
      end
      S_FAULT: begin
        if (settled && ack) begin
          state_d = S_REARM;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_cls_q     <= C_HOLD;
      prev_face_q    <= 3'd0;
      pips_q         <= 7'd0;
      dir_q          <= 2'b00;
      run_len_q      <= '0;
      stable_cnt_q   <= 4'd0;
      result_q       <= 3'd0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_cls_q     <= cls;
      prev_face_q    <= face;
      pips_q         <= pips_d;
      dir_q          <= dir_d;
      run_len_q      <= run_len_d;
      stable_cnt_q   <= stable_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
    end
  end

`ifdef DICE_FACE_RX_SUM_EN
  logic [7:0] roll_sum_q, roll_sum_d, roll_cnt_q, roll_cnt_d;
  logic [8:0] sum_wide;

  always_comb begin
    sum_wide   = {1'b0, roll_sum_q} + {6'd0, result_q};
    roll_sum_d = roll_sum_q;
    roll_cnt_d = roll_cnt_q;
    if (accept) begin
      roll_sum_d = sum_wide[8] ? 8'hFF : sum_wide[7:0];
      roll_cnt_d = (roll_cnt_q == 8'hFF) ? roll_cnt_q : roll_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      roll_sum_q <= 8'd0;
      roll_cnt_q <= 8'd0;
    end else begin
      roll_sum_q <= roll_sum_d;
      roll_cnt_q <= roll_cnt_d;
    end
  end

  assign roll_sum = roll_sum_q;
  assign roll_cnt = roll_cnt_q;
`endif

  assign pips         = pips_q;
  assign dir          = dir_q;
  assign run_len      = run_len_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_dice_face_rx.sv
// Table-driven bench for dice_face_rx: expected outputs queue up when a face is driven, checked after the edge.
module tb_dice_face_rx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] face = 3'd0;
  logic       ack = 1'b0;
  logic [6:0] pips;
  logic [1:0] dir;
  logic [3:0] run_len;
  logic [2:0] result;
  logic       result_valid;
  logic       err;
`ifdef DICE_FACE_RX_SUM_EN
  logic [7:0] roll_sum, roll_cnt;
`endif

  dice_face_rx #(.STABLE_CYCLES(4), .RUN_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .face(face), .ack(ack),
    .pips(pips), .dir(dir), .run_len(run_len), .result(result),
    .result_valid(result_valid),
`ifdef DICE_FACE_RX_SUM_EN
    .roll_sum(roll_sum), .roll_cnt(roll_cnt),
`endif
    .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] face;
    logic       ack;
    logic [6:0] pips;
    logic [1:0] dir;
    logic [3:0] run;
    logic [2:0] res;
    logic       rv;
    logic       err;
  } vec_t;

  localparam logic [6:0] P0 = 7'b0000000, P1 = 7'b0001000, P2 = 7'b1000001,
                         P3 = 7'b1001001, P4 = 7'b1100011, P5 = 7'b1101011,
                         P6 = 7'b1110111;

  vec_t vecs[$];
  vec_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic void add(input logic [2:0] f, input logic a, input logic [6:0] p,
                              input logic [1:0] d, input logic [3:0] r, input logic [2:0] res,
                              input logic rv, input logic e);
    vec_t v;
    v.face = f; v.ack = a; v.pips = p; v.dir = d; v.run = r; v.res = res; v.rv = rv; v.err = e;
    vecs.push_back(v);
  endfunction

  task automatic check_vec(input string name, input vec_t x);
    total_cnt++;
    if (pips === x.pips && dir === x.dir && run_len === x.run && result === x.res &&
        result_valid === x.rv && err === x.err) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got pips=%b dir=%b run=%0d res=%0d rv=%b err=%b, want pips=%b dir=%b run=%0d res=%0d rv=%b err=%b",
               name, pips, dir, run_len, result, result_valid, err,
               x.pips, x.dir, x.run, x.res, x.rv, x.err);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Drive one sample, queue its expectation, and compare once the edge has registered it.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    face = v.face;
    ack  = v.ack;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_vec(name, e);
    $display("vec %s face=%0d ack=%b -> pips=%b dir=%b run=%0d res=%0d rv=%b err=%b",
             name, e.face, e.ack, pips, dir, run_len, result, result_valid, err);
  endtask

  task automatic drive(input logic [2:0] f, input logic a);
    face = f;
    ack  = a;
    @(posedge clock);
    #1;
  endtask

`ifdef DICE_FACE_RX_SUM_EN
  // Settle face 6 and accept it; after the first roll, re-arm with a 6->5->6 step pair.
  task automatic settle6(input bit first, input bit do_ack);
    if (first) drive(3'd6, 1'b0);
    else begin
      drive(3'd5, 1'b0);
      drive(3'd6, 1'b0);
    end
    repeat (4) drive(3'd6, 1'b0);
    check_val("settle6_valid", {7'd0, result_valid}, 8'd1);
    if (do_ack) drive(3'd6, 1'b1);
  endtask
`endif

  initial begin
    vec_t zero;
    zero = '{face: 3'd0, ack: 1'b0, pips: P0, dir: 2'b00, run: 4'd0, res: 3'd0, rv: 1'b0, err: 1'b0};

    // Power-up settle from reset: first sample leaves IDLE, four holds settle face 1.
    repeat (4) add(1, 0, P1, 0, 0, 0, 0, 0);
    repeat (2) add(1, 0, P1, 0, 0, 1, 1, 0);
    // Up run through the 6->1 wrap, then two downs including the 1->6 wrap.
    add(2, 0, P2, 1, 1, 1, 1, 0);
    add(3, 0, P3, 1, 2, 1, 1, 0);
    add(4, 0, P4, 1, 3, 1, 1, 0);
    add(5, 0, P5, 1, 4, 1, 1, 0);
    add(6, 0, P6, 1, 5, 1, 1, 0);
    add(1, 0, P1, 1, 6, 1, 1, 0);
    add(2, 0, P2, 1, 7, 1, 1, 0);
    add(1, 0, P1, 2, 1, 1, 1, 0);
    add(6, 0, P6, 2, 2, 1, 1, 0);
    add(6, 1, P6, 0, 0, 1, 0, 0);
    repeat (5) add(6, 0, P6, 0, 0, 1, 0, 0);
    // Step down to 3, settle, wait ten cycles without ack, then accept.
    add(5, 0, P5, 2, 1, 1, 0, 0);
    add(4, 0, P4, 2, 2, 1, 0, 0);
    add(3, 0, P3, 2, 3, 1, 0, 0);
    repeat (3) add(3, 0, P3, 0, 0, 1, 0, 0);
    add(3, 0, P3, 0, 0, 3, 1, 0);
    repeat (10) add(3, 0, P3, 0, 0, 3, 1, 0);
    add(3, 1, P3, 0, 0, 3, 0, 0);
    repeat (6) add(3, 0, P3, 0, 0, 3, 0, 0);
    repeat (2) add(3, 1, P3, 0, 0, 3, 0, 0);
    // Jump 2->5 while tracking, recover only with a settled face and ack.
    add(2, 0, P2, 2, 1, 3, 0, 0);
    add(5, 0, P5, 3, 0, 3, 0, 1);
    repeat (3) add(5, 1, P5, 0, 0, 3, 0, 1);
    add(5, 0, P5, 0, 0, 3, 0, 1);
    add(5, 1, P5, 0, 0, 3, 0, 0);
    repeat (2) add(5, 0, P5, 0, 0, 3, 0, 0);
    // Settle 6, then illegal face together with ack: the fault wins.
    add(6, 0, P6, 1, 1, 3, 0, 0);
    repeat (3) add(6, 0, P6, 0, 0, 3, 0, 0);
    add(6, 0, P6, 0, 0, 6, 1, 0);
    add(7, 1, P0, 3, 0, 6, 0, 1);
    add(7, 0, P0, 3, 0, 6, 0, 1);
    add(4, 1, P4, 3, 0, 6, 0, 1);
    repeat (3) add(4, 1, P4, 0, 0, 6, 0, 1);
    add(4, 1, P4, 0, 0, 6, 0, 0);

    #2 reset_n = 1'b0;
    #1 check_vec("reset_state", zero);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("t%0d", i), vecs[i]);

    // Settle face 5, then pull reset mid-handshake between clock edges.
    apply("f_up", '{face: 3'd5, ack: 1'b0, pips: P5, dir: 2'b01, run: 4'd1, res: 3'd6, rv: 1'b0, err: 1'b0});
    for (int i = 0; i < 3; i++)
      apply($sformatf("f_hold%0d", i), '{face: 3'd5, ack: 1'b0, pips: P5, dir: 2'b00, run: 4'd0, res: 3'd6, rv: 1'b0, err: 1'b0});
    apply("f_settle", '{face: 3'd5, ack: 1'b0, pips: P5, dir: 2'b00, run: 4'd0, res: 3'd5, rv: 1'b1, err: 1'b0});
    #2 reset_n = 1'b0;
    #1 check_vec("async_reset", zero);
    @(negedge clock);
    reset_n = 1'b1;

`ifdef DICE_FACE_RX_SUM_EN
    check_val("sum_after_reset", roll_sum, 8'd0);
    settle6(1'b1, 1'b1);
    settle6(1'b0, 1'b1);
    settle6(1'b0, 1'b1);
    check_val("roll_sum_18", roll_sum, 8'd18);
    check_val("roll_cnt_3", roll_cnt, 8'd3);
    settle6(1'b0, 1'b0);
    drive(3'd7, 1'b1);
    check_val("fault_wins_err", {7'd0, err}, 8'd1);
    check_val("fault_wins_valid", {7'd0, result_valid}, 8'd0);
    check_val("fault_wins_cnt", roll_cnt, 8'd3);
    check_val("fault_wins_sum", roll_sum, 8'd18);
    #2 reset_n = 1'b0;
    #1;
    check_val("reset_roll_sum", roll_sum, 8'd0);
    check_val("reset_roll_cnt", roll_cnt, 8'd0);
    @(negedge clock);
    reset_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
